// File: rtl/os_array_sched.sv
// Tile scheduler for the output-stationary systolic array.
// Per tile: K operand-buffer reads, a diagonal clc wavefront aligned with each
// PE's first product, a flush long enough for the last product to land in the
// far corner PE, then a row-by-row drain over valid/ready.
module os_array_sched #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_W     = 16,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2,
  localparam int DIAG   = ROWS + COLS - 1,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             buf_rd_en,
  output logic [K_W-1:0]   buf_rd_addr,
  output logic [DIAG-1:0]  clc_diag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row_sel
);

  // Flush length: read latency + diagonal skew to the far corner + MAC latency.
  localparam int F_LEN = RD_LAT + ROWS + COLS - 2 + MAC_LAT;
  localparam int F_W   = $clog2(F_LEN + 1);
  // Taps of the clc delay line; tap t is high t cycles after the addr-0 read.
  localparam int TAP_N = RD_LAT + DIAG;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   r_addr;
  logic [F_W-1:0]   r_fcnt;
  logic [ROW_W-1:0] r_row;
  logic [TAP_N-2:0] r_clc_sr;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_feed_last;
  logic             w_flush_last;
  logic             w_hs;
  logic             w_drain_last;
  logic             w_first;
  logic [TAP_N-1:0] w_taps;

  assign w_accept     = (r_state == S_IDLE) && start && (k_len != '0);
  // The address stops at K-1, so K = 2^K_W-1 never wraps the counter.
  assign w_feed_last  = (r_state == S_FEED) && (r_addr == r_k - K_W'(1));
  assign w_flush_last = (r_state == S_FLUSH) && (r_fcnt == F_W'(F_LEN - 1));
  assign w_hs         = (r_state == S_DRAIN) && out_ready;
  assign w_drain_last = w_hs && (r_row == ROW_W'(ROWS - 1));
  assign w_first      = (r_state == S_FEED) && (r_addr == '0);
  assign w_taps       = {r_clc_sr, w_first};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic for IDLE -> FEED -> FLUSH -> DRAIN -> IDLE.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred
    // latches on paths that do not change state.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)     w_next = S_FEED;
      S_FEED:  if (w_feed_last)  w_next = S_FLUSH;
      S_FLUSH: if (w_flush_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Tile length, read address, flush and drain-row counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_addr <= '0;
      r_fcnt <= '0;
      r_row  <= '0;
    end else begin
      if (w_accept) r_k <= k_len;
      if (r_state == S_FEED) r_addr <= w_feed_last ? '0 : r_addr + K_W'(1);
      if (r_state == S_FLUSH) r_fcnt <= w_flush_last ? '0 : r_fcnt + F_W'(1);
      if (w_hs) r_row <= w_drain_last ? '0 : r_row + ROW_W'(1);
    end
  end

  // clc delay line: carries the addr-0 marker across RD_LAT plus the diagonal
  // skew; it keeps shifting through FLUSH so the far diagonals still fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clc_sr <= '0;
    else        r_clc_sr <= {r_clc_sr[TAP_N-3:0], w_first};
  end

  // Single-cycle status pulses: err for a zero-length request, done after the
  // final row is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_err  <= (r_state == S_IDLE) && start && (k_len == '0);
      r_done <= w_drain_last;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign buf_rd_en   = (r_state == S_FEED);
  assign buf_rd_addr = (r_state == S_FEED) ? r_addr : '0;
  assign clc_diag    = w_taps[TAP_N-1:RD_LAT];
  assign out_valid   = (r_state == S_DRAIN);
  assign out_row_sel = r_row;

endmodule

// File: tb/tb_os_array_sched.sv
// Self-checking bench for os_array_sched. A driver issues directed and random
// tile traffic and, each cycle, pushes the expected output snapshot computed
// from tile arithmetic; a monitor pops and compares on the falling edge.
module tb_os_array_sched;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K_W     = 16;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 2;
  localparam int DIAG    = ROWS + COLS - 1;
  localparam int F_LEN   = RD_LAT + ROWS + COLS - 2 + MAC_LAT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [K_W-1:0]  k_len;
  logic            busy, done, err, buf_rd_en, out_valid, out_ready;
  logic [K_W-1:0]  buf_rd_addr;
  logic [DIAG-1:0] clc_diag;
  logic [1:0]      out_row_sel;

  os_array_sched #(
    .ROWS(ROWS), .COLS(COLS), .K_W(K_W), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .err(err),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .clc_diag(clc_diag),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_sel(out_row_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              c;
    logic            busy;
    logic            rd_en;
    logic [K_W-1:0]  addr;
    logic [DIAG-1:0] clc;
    logic            valid;
    logic [1:0]      sel;
    logic            done;
    logic            err;
  } snap_t;

  snap_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one tile described by its accept cycle, length and the
  // number of rows already handed over.
  bit m_busy;
  int m_c0, m_k, m_drain, m_rows, m_done_at, m_err_at;

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
  endtask

  function automatic void model_clear();
    m_busy = 0; m_c0 = 0; m_k = 0; m_drain = 0; m_rows = 0;
    m_done_at = -1; m_err_at = -1;
  endfunction

  function automatic snap_t predict(input int c);
    snap_t s;
    s.c     = c;
    s.busy  = m_busy;
    s.rd_en = m_busy && (c >= m_c0 + 1) && (c <= m_c0 + m_k);
    s.addr  = s.rd_en ? K_W'(c - m_c0 - 1) : '0;
    for (int d = 0; d < DIAG; d++)
      s.clc[d] = m_busy && (c == m_c0 + 1 + RD_LAT + d);
    s.valid = m_busy && (c >= m_drain);
    s.sel   = 2'(m_rows);
    s.done  = (c == m_done_at);
    s.err   = (c == m_err_at);
    return s;
  endfunction

  function automatic void model_update(input int c, input logic st,
                                       input logic [K_W-1:0] k, input logic rdy);
    if (!m_busy) begin
      if (st && k != 0) begin
        m_busy = 1; m_c0 = c; m_k = int'(k); m_rows = 0;
        m_drain = c + int'(k) + 1 + F_LEN;
      end else if (st) begin
        m_err_at = c + 1;
      end
    end else if (c >= m_drain && rdy) begin
      m_rows++;
      if (m_rows == ROWS) begin
        m_busy = 0; m_rows = 0; m_done_at = c + 1;
      end
    end
  endfunction

  task automatic step(input logic st, input logic [K_W-1:0] k, input logic rdy);
    start = st; k_len = k; out_ready = rdy;
    sb_q.push_back(predict(cyc));
    model_update(cyc, st, k, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; k_len = '0; out_ready = 1'b0;
    model_clear();
    sb_q.push_back(predict(cyc));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One tile with out_ready held low for stall_n cycles while row stall_row is offered.
  task automatic run_tile(input int k, input int stall_row, input int stall_n);
    int stalled = 0;
    int guard   = 0;
    logic rdy;
    step(1'b1, K_W'(k), 1'b1);
    while (m_busy && guard < 2000) begin
      rdy = 1'b1;
      if (cyc >= m_drain && m_rows == stall_row && stalled < stall_n) begin
        rdy = 1'b0; stalled++;
      end
      step(1'b0, '0, rdy);
      guard++;
    end
  endtask

  // Monitor: compare every output against the snapshot queued for this cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      snap_t s;
      s = sb_q.pop_front();
      check("busy",        s.c, 32'(busy),        32'(s.busy));
      check("buf_rd_en",   s.c, 32'(buf_rd_en),   32'(s.rd_en));
      check("buf_rd_addr", s.c, 32'(buf_rd_addr), 32'(s.addr));
      check("clc_diag",    s.c, 32'(clc_diag),    32'(s.clc));
      check("out_valid",   s.c, 32'(out_valid),   32'(s.valid));
      check("out_row_sel", s.c, 32'(out_row_sel), 32'(s.sel));
      check("done",        s.c, 32'(done),        32'(s.done));
      check("err",         s.c, 32'(err),         32'(s.err));
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // K=4 and K=1 tiles with the consumer always ready.
    run_tile(4, -1, 0);
    step(1'b0, '0, 1'b1);
    run_tile(1, -1, 0);
    step(1'b0, '0, 1'b1);

    // Zero-length request raises err only.
    step(1'b1, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Starts while busy are ignored; a start held into the done cycle is taken.
    step(1'b1, K_W'(3), 1'b1);
    for (int g = 0; g < 200 && m_busy; g++)
      step(1'b1, K_W'($urandom_range(0, 5)), 1'b1);
    step(1'b1, K_W'(2), 1'b1);
    for (int g = 0; g < 200 && m_busy; g++) step(1'b0, '0, 1'b1);

    // Consumer stalls 3 cycles on row 2.
    run_tile(2, 2, 3);
    step(1'b0, '0, 1'b1);

    // Reset while addr 2 of an 8-long tile is on the bus, then a fresh tile.
    step(1'b1, K_W'(8), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b1);
    run_tile(8, -1, 0);

    // Random traffic: lengths, idle gaps, zero-length requests, stray starts, backpressure.
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step(1'b0, '0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) step(1'b1, '0, 1'b1);
      step(1'b1, K_W'($urandom_range(1, 20)), 1'b1);
      for (int g = 0; g < 2000 && m_busy; g++)
        step(1'($urandom_range(0, 3) == 0), K_W'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    @(negedge clk); #1;
    check("scoreboard_empty", cyc, 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
